// File: rtl/snn_output_classifier.sv
// Scans the output spike count RAM after a run and reports the winning neuron
// (max count, lowest index on ties), its count, the total count and tie/no-spike flags.
module snn_output_classifier #(
    parameter int NUM_OUTPUTS            = 1,
    parameter int OUTPUT_SPIKE_ADDR_BITS = 4,
    parameter int COUNT_WIDTH            = 32
) (
    input  logic                                        S_AXI_ACLK,
    input  logic                                        S_AXI_ARESETN,
    input  logic                                        start,
    output logic                                        mem_req,
    output logic [OUTPUT_SPIKE_ADDR_BITS-1:0]           mem_addr,
    input  logic [COUNT_WIDTH-1:0]                      mem_data_in,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        result_valid,
    output logic [OUTPUT_SPIKE_ADDR_BITS-1:0]           winner_idx,
    output logic [COUNT_WIDTH-1:0]                      winner_count,
    output logic [COUNT_WIDTH+OUTPUT_SPIKE_ADDR_BITS-1:0] total_count,
    output logic                                        tie,
    output logic                                        no_spike,
    output logic [1:0]                                  dbg_state
);

    localparam int AW = OUTPUT_SPIKE_ADDR_BITS;
    localparam int CW = AW + 1;
    localparam int TW = COUNT_WIDTH + AW;
    localparam logic [CW-1:0] LAST_CNT  = CW'(NUM_OUTPUTS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_OUTPUTS - 1);

    // Handshake: start is a 1-cycle request honoured only in IDLE; done is a 1-cycle
    // pulse with results valid from that cycle; mem_data_in must be valid the cycle
    // after mem_addr is presented with mem_req high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]          r_cnt;
    logic [AW-1:0]          r_addr;
    logic [COUNT_WIDTH-1:0] r_max;
    logic [AW-1:0]          r_idx;
    logic [TW-1:0]          r_total;
    logic                   r_tie;

    logic [COUNT_WIDTH-1:0] r_winner_count;
    logic [AW-1:0]          r_winner_idx;
    logic [TW-1:0]          r_total_count;
    logic                   r_tie_out;
    logic                   r_no_spike;
    logic                   r_result_valid;

    logic                   w_data_vld;
    logic                   w_last;
    logic [AW-1:0]          w_data_idx;
    logic [COUNT_WIDTH-1:0] w_max_nxt;
    logic [AW-1:0]          w_idx_nxt;
    logic [TW-1:0]          w_total_nxt;
    logic                   w_tie_nxt;

    // r_cnt is the number of cycles spent in SCAN; data for entry r_cnt-1 is on the bus.
    assign w_data_vld = (r_state == S_SCAN) && (r_cnt != '0);
    assign w_last     = w_data_vld && (r_cnt == LAST_CNT);
    assign w_data_idx = r_cnt[AW-1:0] - AW'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_max_nxt   = r_max;
        w_idx_nxt   = r_idx;
        w_tie_nxt   = r_tie;
        w_total_nxt = r_total;
        if (w_data_vld) begin
            w_total_nxt = r_total + {{AW{1'b0}}, mem_data_in};
            if (mem_data_in > r_max) begin
                w_max_nxt = mem_data_in;
                w_idx_nxt = w_data_idx;
                w_tie_nxt = 1'b0;
            end else if ((mem_data_in == r_max) && (mem_data_in != '0)) begin
                w_tie_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_cnt          <= '0;
            r_addr         <= '0;
            r_max          <= '0;
            r_idx          <= '0;
            r_total        <= '0;
            r_tie          <= 1'b0;
            r_winner_count <= '0;
            r_winner_idx   <= '0;
            r_total_count  <= '0;
            r_tie_out      <= 1'b0;
            r_no_spike     <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt          <= '0;
                        r_addr         <= '0;
                        r_max          <= '0;
                        r_idx          <= '0;
                        r_total        <= '0;
                        r_tie          <= 1'b0;
                        r_winner_count <= '0;
                        r_winner_idx   <= '0;
                        r_total_count  <= '0;
                        r_tie_out      <= 1'b0;
                        r_no_spike     <= 1'b0;
                        r_result_valid <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_cnt   <= r_cnt + CW'(1);
                    r_max   <= w_max_nxt;
                    r_idx   <= w_idx_nxt;
                    r_total <= w_total_nxt;
                    r_tie   <= w_tie_nxt;
                    // Address saturates at the last entry so it never wraps back to 0.
                    if (r_addr != LAST_ADDR) begin
                        r_addr <= r_addr + AW'(1);
                    end
                    if (w_last) begin
                        r_addr         <= '0;
                        r_winner_count <= w_max_nxt;
                        r_winner_idx   <= w_idx_nxt;
                        r_total_count  <= w_total_nxt;
                        r_tie_out      <= w_tie_nxt;
                        r_no_spike     <= (w_total_nxt == '0);
                        r_result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req      = (r_state == S_SCAN);
    assign mem_addr     = r_addr;
    assign busy         = (r_state == S_SCAN);
    assign done         = (r_state == S_DONE);
    assign result_valid = r_result_valid;
    assign winner_idx   = r_winner_idx;
    assign winner_count = r_winner_count;
    assign total_count  = r_total_count;
    assign tie          = r_tie_out;
    assign no_spike     = r_no_spike;
    assign dbg_state    = r_state;

endmodule
